// File: rtl/sweep_acq_control_pkg.sv
// Shared types and constants for the DAC0 S-curve sweep controller.
// Holds the FSM state encoding and the default header tag.
package sweep_acq_control_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CFGWAIT = 3'd2,
        HEADER  = 3'd3,
        ACQ     = 3'd4,
        DRAIN   = 3'd5,
        ONEDONE = 3'd6,
        FINISH  = 3'd7
    } state_t;

    localparam logic [5:0] HEADER_TAG = 6'b000000;
    localparam logic [9:0] DAC_MAX    = 10'd1023;

endpackage

// File: rtl/sweep_acq_control_edge_detect.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
// The pulse is combinational from the current input and the registered previous level.
module sweep_acq_control_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/sweep_acq_control.sv
// DAC0 threshold sweep controller for the Microroc S-curve test:
// load slow control, acquire N packages, forward header plus FIFO words per DAC code.
import sweep_acq_control_pkg::*;

module sweep_acq_control #(
    parameter logic [5:0] HEADER_TAG = sweep_acq_control_pkg::HEADER_TAG
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        SweepStart,
    output logic        SingleACQStart,
    output logic        OneDACDone,
    output logic        ACQDone,
    input  logic [9:0]  StartDAC0,
    input  logic [9:0]  EndDAC0,
    input  logic [15:0] MaxPackageNumber,
    input  logic        ParallelData_en,
    output logic [9:0]  OutDAC0,
    output logic        LoadSCParameter,
    input  logic        MicrorocConfigDone,
    input  logic [15:0] SweepACQFifoData,
    output logic        SweepACQFifoData_rden,
    output logic [15:0] SweepACQData,
    output logic        SweepACQData_en
);

    state_t      state_q;
    logic [9:0]  cur_dac_q;
    logic [9:0]  end_dac_q;
    logic [15:0] max_pkg_q;
    logic [15:0] pkg_cnt_q;
    logic [15:0] pkg_cnt_d;
    logic        drain_q;
    logic        acq_start_q;
    logic        one_done_q;
    logic        acq_done_q;
    logic [9:0]  out_dac_q;
    logic        load_q;
    logic        rden_q;
    logic        word_en_q;
    logic        fifo_sel_q;
    logic [15:0] hdr_q;
    logic        start_rise;
    logic        pkg_rise;
    logic        last_dac;

    sweep_acq_control_edge_detect u_start_edge (
        .clk_i  (Clk),
        .rst_ni (reset_n),
        .d_i    (SweepStart),
        .rise_o (start_rise)
    );

    sweep_acq_control_edge_detect u_pkg_edge (
        .clk_i  (Clk),
        .rst_ni (reset_n),
        .d_i    (ParallelData_en),
        .rise_o (pkg_rise)
    );

    assign pkg_cnt_d = pkg_cnt_q + 16'd1;
    // >= also covers Start > End; the 1023 guard keeps CurDAC from wrapping
    assign last_dac  = (cur_dac_q >= end_dac_q) || (cur_dac_q == DAC_MAX);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_dac_q   <= '0;
            end_dac_q   <= '0;
            max_pkg_q   <= '0;
            pkg_cnt_q   <= '0;
            drain_q     <= 1'b0;
            acq_start_q <= 1'b0;
            one_done_q  <= 1'b0;
            acq_done_q  <= 1'b0;
            out_dac_q   <= '0;
            load_q      <= 1'b0;
            rden_q      <= 1'b0;
            word_en_q   <= 1'b0;
            fifo_sel_q  <= 1'b0;
            hdr_q       <= '0;
        end else begin
            load_q     <= 1'b0;
            one_done_q <= 1'b0;
            acq_done_q <= 1'b0;
            rden_q     <= 1'b0;
            // FIFO word is valid the cycle after rden and is passed straight through
            word_en_q  <= rden_q;
            fifo_sel_q <= rden_q;
            unique case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        cur_dac_q <= StartDAC0;
                        end_dac_q <= EndDAC0;
                        max_pkg_q <= MaxPackageNumber;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    out_dac_q <= cur_dac_q;
                    load_q    <= 1'b1;
                    state_q   <= CFGWAIT;
                end
                CFGWAIT: begin
                    if (MicrorocConfigDone) begin
                        state_q <= HEADER;
                    end
                end
                HEADER: begin
                    hdr_q       <= {HEADER_TAG, cur_dac_q};
                    word_en_q   <= 1'b1;
                    fifo_sel_q  <= 1'b0;
                    pkg_cnt_q   <= '0;
                    acq_start_q <= 1'b1;
                    state_q     <= ACQ;
                end
                ACQ: begin
                    if (pkg_cnt_q >= max_pkg_q) begin
                        acq_start_q <= 1'b0;
                        drain_q     <= 1'b0;
                        state_q     <= DRAIN;
                    end else if (pkg_rise) begin
                        pkg_cnt_q <= pkg_cnt_d;
                        rden_q    <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_q) begin
                        state_q <= ONEDONE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                ONEDONE: begin
                    one_done_q <= 1'b1;
                    if (last_dac) begin
                        state_q <= FINISH;
                    end else begin
                        cur_dac_q <= cur_dac_q + 10'd1;
                        state_q   <= LOAD;
                    end
                end
                FINISH: begin
                    acq_done_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SingleACQStart        = acq_start_q;
    assign OneDACDone            = one_done_q;
    assign ACQDone               = acq_done_q;
    assign OutDAC0               = out_dac_q;
    assign LoadSCParameter       = load_q;
    assign SweepACQFifoData_rden = rden_q;
    assign SweepACQData_en       = word_en_q;
    assign SweepACQData          = fifo_sel_q ? SweepACQFifoData : hdr_q;

endmodule

// File: tb/tb_sweep_acq_control.sv
// Scoreboard bench for sweep_acq_control: a sweep-level reference model
// queues expected words and DAC loads; a monitor compares what the DUT emits.
module tb_sweep_acq_control;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        SweepStart = 1'b0;
    logic        SingleACQStart;
    logic        OneDACDone;
    logic        ACQDone;
    logic [9:0]  StartDAC0 = '0;
    logic [9:0]  EndDAC0 = '0;
    logic [15:0] MaxPackageNumber = '0;
    logic        ParallelData_en = 1'b0;
    logic [9:0]  OutDAC0;
    logic        LoadSCParameter;
    logic        MicrorocConfigDone = 1'b0;
    logic [15:0] SweepACQFifoData;
    logic        SweepACQFifoData_rden;
    logic [15:0] SweepACQData;
    logic        SweepACQData_en;

    always #5 Clk = ~Clk;

    sweep_acq_control dut (
        .Clk                   (Clk),
        .reset_n               (reset_n),
        .SweepStart            (SweepStart),
        .SingleACQStart        (SingleACQStart),
        .OneDACDone            (OneDACDone),
        .ACQDone               (ACQDone),
        .StartDAC0             (StartDAC0),
        .EndDAC0               (EndDAC0),
        .MaxPackageNumber      (MaxPackageNumber),
        .ParallelData_en       (ParallelData_en),
        .OutDAC0               (OutDAC0),
        .LoadSCParameter       (LoadSCParameter),
        .MicrorocConfigDone    (MicrorocConfigDone),
        .SweepACQFifoData      (SweepACQFifoData),
        .SweepACQFifoData_rden (SweepACQFifoData_rden),
        .SweepACQData          (SweepACQData),
        .SweepACQData_en       (SweepACQData_en)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [15:0] exp_q[$];
    logic [9:0]  load_q[$];
    int onedone_cnt = 0;
    int acqdone_cnt = 0;
    int rden_cnt = 0;
    int exp_points = 0;
    int exp_rden = 0;
    bit rden_prev = 1'b0;
    bit hold5 = 1'b0;
    logic [15:0] fifo_val = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // FIFO model: restarts per DAC point, +3 per read, data valid after rden
    assign SweepACQFifoData = fifo_val;
    always @(posedge Clk) begin
        if (LoadSCParameter) fifo_val <= '0;
        else if (SweepACQFifoData_rden) fifo_val <= fifo_val + 16'd3;
    end

    initial forever begin
        @(negedge Clk);
        if (reset_n && LoadSCParameter) begin
            repeat (7) @(negedge Clk);
            MicrorocConfigDone = 1'b1;
            @(negedge Clk);
            MicrorocConfigDone = 1'b0;
        end
    end

    initial forever begin
        @(negedge Clk);
        if (SingleACQStart) begin
            ParallelData_en = 1'b1;
            repeat (hold5 ? 5 : $urandom_range(1, 3)) @(negedge Clk);
            ParallelData_en = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge Clk);
        end
    end

    always @(negedge Clk) begin
        if (!reset_n) begin
            rden_prev = 1'b0;
        end else begin
            if (rden_prev) chk("rden_to_en", SweepACQData_en, 1);
            if (SweepACQData_en) begin
                chk("word_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("data_word", SweepACQData, exp_q.pop_front());
            end
            if (LoadSCParameter) begin
                chk("load_expected", int'(load_q.size() > 0), 1);
                if (load_q.size() > 0) chk("load_dac", OutDAC0, load_q.pop_front());
            end
            if (SweepACQFifoData_rden) rden_cnt++;
            if (OneDACDone) onedone_cnt++;
            if (ACQDone) acqdone_cnt++;
            rden_prev = SweepACQFifoData_rden;
        end
    end

    task automatic start_sweep(input int s, input int e, input int m);
        int d;
        int lat;
        d = s;
        exp_points = 0;
        forever begin
            load_q.push_back(10'(d));
            exp_q.push_back(16'(d));
            for (int i = 1; i <= m; i++) exp_q.push_back(16'(3 * i));
            exp_points++;
            if (d >= e || d == 1023) break;
            d++;
        end
        exp_rden = exp_points * m;
        onedone_cnt = 0;
        acqdone_cnt = 0;
        rden_cnt = 0;
        @(negedge Clk);
        StartDAC0 = 10'(s);
        EndDAC0 = 10'(e);
        MaxPackageNumber = 16'(m);
        SweepStart = 1'b1;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
            SweepStart = 1'b0;
        end while (!LoadSCParameter && lat < 10);
        chk("start_to_load_latency", lat, 2);
        StartDAC0 = 10'($urandom);
        EndDAC0 = 10'($urandom);
        MaxPackageNumber = 16'($urandom_range(0, 30));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!ACQDone && n < 6000) begin
            @(negedge Clk);
            n++;
        end
        chk("sweep_finished", int'(n < 6000), 1);
        repeat (4) @(negedge Clk);
        chk("onedone_count", onedone_cnt, exp_points);
        chk("acqdone_count", acqdone_cnt, 1);
        chk("rden_count", rden_cnt, exp_rden);
        chk("words_left", exp_q.size(), 0);
        chk("loads_left", load_q.size(), 0);
        exp_q.delete();
        load_q.delete();
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_ctl"}, int'({SingleACQStart, OneDACDone, ACQDone,
            LoadSCParameter, SweepACQFifoData_rden, SweepACQData_en}), 0);
        chk({name, "_dac"}, OutDAC0, 0);
        chk({name, "_data"}, SweepACQData, 0);
    endtask

    initial begin
        int s;
        int e;
        int n;
        repeat (3) @(negedge Clk);
        chk_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        start_sweep(500, 505, 10);
        wait_done();
        start_sweep(7, 7, 0);
        wait_done();
        start_sweep(10, 5, 2);
        wait_done();

        hold5 = 1'b1;
        start_sweep(20, 22, 3);
        fork
            begin
                repeat (3) begin
                    repeat (15) @(negedge Clk);
                    SweepStart = 1'b1;
                    @(negedge Clk);
                    SweepStart = 1'b0;
                end
            end
            wait_done();
        join
        hold5 = 1'b0;

        repeat (4) begin
            s = $urandom_range(0, 1023);
            e = s + $urandom_range(0, 3) - 1;
            if (e < 0) e = 0;
            if (e > 1023) e = 1023;
            start_sweep(s, e, $urandom_range(1, 5));
            wait_done();
        end
        start_sweep(1022, 1023, 1);
        wait_done();

        start_sweep(500, 505, 4);
        n = 0;
        while (!(SingleACQStart && OutDAC0 == 10'd502) && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        chk("reached_dac_502", int'(n < 3000), 1);
        #2 reset_n = 1'b0;
        #1 chk_outputs_zero("midsweep_reset");
        exp_q.delete();
        load_q.delete();
        repeat (12) @(negedge Clk);
        reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        start_sweep(500, 502, 3);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sweep_acq_control.md
Name: sweep_acq_control

Overview:
- Drives a DAC0 threshold sweep for the Microroc S-curve test.
- For each DAC0 code from StartDAC0 to EndDAC0 it:
  - loads slow-control parameters and waits for the configuration to finish;
  - runs one acquisition until MaxPackageNumber packages are counted;
  - forwards a header word plus the FIFO data words to the USB/readout path.
- Sits between the top-level command decoder, the slow-control loader, the acquisition FIFO and the readout mux.

Parameters:
- HEADER_TAG, 6'b000000, upper 6 bits of the per-DAC header word.

Ports:
- Clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- SweepStart  in  1  start sweep; rising edge detected, ignored while busy.
- SingleACQStart  out  1  high while one DAC point is acquiring.
- OneDACDone  out  1  one-cycle pulse after each DAC point completes.
- ACQDone  out  1  one-cycle pulse after the whole sweep completes.
- StartDAC0  in  10  first DAC0 code.
- EndDAC0  in  10  last DAC0 code.
- MaxPackageNumber  in  16  packages to collect per DAC point.
- ParallelData_en  in  1  package-ready strobe; each rising edge is one package.
- OutDAC0  out  10  DAC0 code for slow control.
- LoadSCParameter  out  1  one-cycle slow-control load request.
- MicrorocConfigDone  in  1  slow-control load finished (pulse).
- SweepACQFifoData  in  16  acquisition FIFO read data, valid the cycle after rden.
- SweepACQFifoData_rden  out  1  FIFO read strobe.
- SweepACQData  out  16  output data word.
- SweepACQData_en  out  1  output word valid, one cycle per word.

Behaviour:
- Reset: all outputs 0, OutDAC0=0, counters 0, state IDLE.
- StartDAC0, EndDAC0 and MaxPackageNumber are latched on the sweep-start edge; later changes take effect only on the next sweep.
- States:
  - IDLE: on a SweepStart rising edge, CurDAC<=StartDAC0, then go to LOAD.
  - LOAD: OutDAC0<=CurDAC, LoadSCParameter=1 for exactly one cycle, then go to CFGWAIT.
  - CFGWAIT: hold OutDAC0 and wait for MicrorocConfigDone=1, then go to HEADER.
  - HEADER: emit one cycle SweepACQData={HEADER_TAG,CurDAC} with SweepACQData_en=1, clear PkgCnt, then go to ACQ.
  - ACQ: SingleACQStart=1.
    - Each ParallelData_en rising edge: PkgCnt+1 and a one-cycle SweepACQFifoData_rden pulse in the next cycle.
    - The cycle after rden: SweepACQData<=SweepACQFifoData, SweepACQData_en=1.
    - When PkgCnt reaches MaxPackageNumber, go to DRAIN.
  - DRAIN: SingleACQStart=0; wait 2 cycles so the last rden/data pair completes; further ParallelData_en edges are ignored. Then go to ONEDONE.
  - ONEDONE: OneDACDone=1 for one cycle.
    - If CurDAC==EndDAC (latched), go to FINISH.
    - Otherwise CurDAC<=CurDAC+1, then go to LOAD.
  - FINISH: ACQDone=1 for one cycle, then go to IDLE.
- Boundary conditions:
  - MaxPackageNumber==0: ACQ exits immediately (SingleACQStart high for one cycle); no rden is issued.
  - StartDAC0>EndDAC0: only StartDAC0 is processed, because completion also triggers on CurDAC>=EndDAC. CurDAC never wraps past 1023.
  - StartDAC0==EndDAC0: exactly one DAC point.
  - ParallelData_en held high for several cycles counts as one package.
  - SweepStart while not in IDLE is ignored.
- Latencies: SweepStart edge to LoadSCParameter is 2 cycles; ParallelData_en edge to rden is 1 cycle; rden to SweepACQData_en is 1 cycle.
- Reset asserted mid-sweep returns the block to IDLE immediately with all outputs cleared.

Decomposition:
- Shared package: state encoding localparams (IDLE, LOAD, CFGWAIT, HEADER, ACQ, DRAIN, ONEDONE, FINISH) and HEADER_TAG.
- One optional sub-module: edge_detect (rising-edge detector), used for SweepStart and ParallelData_en.
- All else is a single FSM plus datapath.

Test Plan:
- Start=500, End=505, Max=10, ConfigDone returned 8 cycles after each LoadSCParameter, 10 ParallelData_en pulses per point ->
  - 6 LoadSCParameter pulses with OutDAC0=500..505;
  - 6 OneDACDone pulses and 1 ACQDone;
  - 66 SweepACQData_en words (6 headers 0x01F4..0x01F9, each followed by 10 FIFO words).
- FIFO model increments its data by 3 on each rden -> forwarded words within a point read 3,6,...,30 in order, each 1 cycle after its rden.
- Start=End=7, Max=0 -> 1 LoadSCParameter, header 0x0007, no rden, OneDACDone then ACQDone.
- Start=10, End=5, Max=2 -> only DAC 10 processed, 2 data words, ACQDone.
- SweepStart re-pulsed mid-sweep and ParallelData_en held high 5 cycles -> sweep unaffected; the held pulse counts as 1 package.
- reset_n low during ACQ at DAC 502 -> all outputs 0 at once; a new SweepStart restarts from StartDAC0.
